// File: rtl/synchronous_reset_sequencer.sv
// Staged reset release: STAGES active-high resets drop one by one after reset_in deasserts.
// Define RESET_SEQ_ACK_EN to add the stage_ack handshake before each following stage starts.
module synchronous_reset_sequencer #(
    parameter int LENGTH    = 7,
    parameter int STAGES    = 4,
    parameter int STAGE_GAP = 3
) (
    input  logic              clk,
    input  logic              reset_in,
`ifdef RESET_SEQ_ACK_EN
    input  logic [STAGES-1:0] stage_ack,
`endif
    output logic [STAGES-1:0] reset_out,
    output logic              sequence_done
);

    localparam int MAXC = (LENGTH > STAGE_GAP) ? LENGTH : STAGE_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int KW   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CW-1:0] LEN_LAST = CW'(LENGTH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(STAGES - 1);

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        STAGGER  = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Every register is all-zero in the reset state (released mask instead of reset mask,
    // up-counter from zero), so zero-initialised flops start exactly as after a reset sample.
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [STAGES-1:0] rel_q, rel_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            k_q     <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        rel_d   = rel_q;
        done_d  = done_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == LEN_LAST) begin
                    rel_d[0] = 1'b1;
                    cnt_d    = '0;
`ifdef RESET_SEQ_ACK_EN
                    k_d      = '0;
                    state_d  = WAIT_ACK;
`else
                    if (STAGES == 1) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d     = KW'(1);
                        state_d = STAGGER;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STAGGER: begin
                if (cnt_q == GAP_LAST) begin
                    rel_d[k_q] = 1'b1;
                    cnt_d      = '0;
`ifdef RESET_SEQ_ACK_EN
                    state_d    = WAIT_ACK;
`else
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef RESET_SEQ_ACK_EN
            // The acknowledge of stage k is a level, looked at only while waiting on stage k.
            WAIT_ACK: begin
                if (stage_ack[k_q]) begin
                    cnt_d = '0;
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = STAGGER;
                    end
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    assign reset_out     = ~rel_q;
    assign sequence_done = done_q;

endmodule

// File: tb/tb_synchronous_reset_sequencer.sv
// Bench for synchronous_reset_sequencer: a 3-stage and a 1-stage instance share clock and reset_in.
// Outputs are compared each negedge against release times derived from the reset/ack sample cycles.
module tb_synchronous_reset_sequencer;

    localparam int  L   = 7;
    localparam int  G   = 4;
    localparam longint INF = 64'sd1 <<< 60;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [2:0] rst_a;
    logic       done_a;
    logic [0:0] rst_b;
    logic       done_b;
    logic [2:0] ack_a = 3'b000;
    logic [0:0] ack_b = 1'b0;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    longint rel_t [2][3];
    longint ack_t [2][3];
    longint done_t [2];

    always #5 clk = ~clk;

    synchronous_reset_sequencer #(.LENGTH(L), .STAGES(3), .STAGE_GAP(G)) dut_a (
        .clk           (clk),
        .reset_in      (reset_in),
`ifdef RESET_SEQ_ACK_EN
        .stage_ack     (ack_a),
`endif
        .reset_out     (rst_a),
        .sequence_done (done_a)
    );

    synchronous_reset_sequencer #(.LENGTH(L), .STAGES(1), .STAGE_GAP(G)) dut_b (
        .clk           (clk),
        .reset_in      (reset_in),
`ifdef RESET_SEQ_ACK_EN
        .stage_ack     (ack_b),
`endif
        .reset_out     (rst_b),
        .sequence_done (done_b)
    );

    function automatic int nst(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic logic ack_of(input int i, input int k);
        return (i == 0) ? ack_a[k] : ack_b[0];
    endfunction

    // A reset sample at cycle e fixes every release time (timed) or only the first (ack mode).
    task automatic load(input longint e);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                ack_t[i][k] = INF;
`ifdef RESET_SEQ_ACK_EN
                rel_t[i][k] = (k == 0) ? e + L : INF;
`else
                rel_t[i][k] = (k < nst(i)) ? e + L + k * G : INF;
`endif
            end
`ifdef RESET_SEQ_ACK_EN
            done_t[i] = INF;
`else
            done_t[i] = e + L + (nst(i) - 1) * G;
`endif
        end
    endtask

    initial load(0);

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset_in) begin
            load(cyc);
        end else begin
`ifdef RESET_SEQ_ACK_EN
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < nst(i); k++) begin
                    if (rel_t[i][k] != INF && cyc > rel_t[i][k] && ack_t[i][k] == INF && ack_of(i, k)) begin
                        ack_t[i][k] = cyc;
                        if (k == nst(i) - 1) done_t[i] = cyc;
                        else rel_t[i][k+1] = cyc + G;
                    end
                end
            end
`endif
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] ea;
        logic [0:0] eb;
        for (int k = 0; k < 3; k++) ea[k] = !(cyc >= rel_t[0][k]);
        eb[0] = !(cyc >= rel_t[1][0]);
        check("model_rst_a", 32'(rst_a), 32'(ea));
        check("model_done_a", 32'(done_a), 32'(cyc >= done_t[0]));
        check("model_rst_b", 32'(rst_b), 32'(eb));
        check("model_done_b", 32'(done_b), 32'(cyc >= done_t[1]));
    end

    task automatic at_neg(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    task automatic lit(input int n, input logic [2:0] ea, input logic eda, input logic eb, input logic edb);
        at_neg(n);
        check("lit_rst_a", 32'(rst_a), 32'(ea));
        check("lit_done_a", 32'(done_a), 32'(eda));
        check("lit_rst_b", 32'(rst_b), 32'(eb));
        check("lit_done_b", 32'(done_b), 32'(edb));
    endtask

    task automatic pulse(input int p);
        at_neg(p - 1);
        reset_in = 1'b1;
        at_neg(p);
        reset_in = 1'b0;
    endtask

    initial begin
        @(negedge clk);
`ifdef RESET_SEQ_ACK_EN
        lit(1,  3'b111, 1'b0, 1'b1, 1'b0);
        lit(7,  3'b110, 1'b0, 1'b0, 1'b0);
        lit(57, 3'b110, 1'b0, 1'b0, 1'b0);
        ack_a = 3'b011;
        ack_b = 1'b1;
        lit(58, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(61, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(62, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(66, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(67, 3'b000, 1'b0, 1'b0, 1'b1);
        lit(80, 3'b000, 1'b0, 1'b0, 1'b1);
        ack_a = 3'b111;
        lit(81, 3'b000, 1'b1, 1'b0, 1'b1);
        pulse(90);
        lit(90, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(97, 3'b110, 1'b0, 1'b0, 1'b0);
        lit(98, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(102, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(107, 3'b000, 1'b0, 1'b0, 1'b1);
        lit(108, 3'b000, 1'b1, 1'b0, 1'b1);
        at_neg(115);
`else
        lit(1,  3'b111, 1'b0, 1'b1, 1'b0);
        lit(6,  3'b111, 1'b0, 1'b1, 1'b0);
        lit(7,  3'b110, 1'b0, 1'b0, 1'b1);
        lit(10, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(11, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(14, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(15, 3'b000, 1'b1, 1'b0, 1'b1);
        pulse(20);
        lit(20, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(26, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(27, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(31, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(35, 3'b000, 1'b1, 1'b0, 1'b1);
        pulse(38);
        lit(38, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(45, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(49, 3'b100, 1'b0, 1'b0, 1'b1);
        pulse(51);
        lit(51, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(52, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(57, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(58, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(62, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(66, 3'b000, 1'b1, 1'b0, 1'b1);
        at_neg(70);
        reset_in = 1'b1;
        lit(80, 3'b111, 1'b0, 1'b1, 1'b0);
        at_neg(90);
        reset_in = 1'b0;
        lit(96, 3'b111, 1'b0, 1'b1, 1'b0);
        lit(97, 3'b110, 1'b0, 1'b0, 1'b1);
        lit(101, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(104, 3'b100, 1'b0, 1'b0, 1'b1);
        lit(105, 3'b000, 1'b1, 1'b0, 1'b1);
        lit(115, 3'b000, 1'b1, 1'b0, 1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
